sub32_serial: RTL

- Multi-cycle 32-bit subtractor computing diff = a - b - b_in, CHUNK bits per clock, with a registered borrow chain.
- Inverse counterpart of the team's 32-bit adder chain. Same chunked-propagation idea, but sequenced over cycles instead of cascaded combinationally.
- Sits in the datapath as a low-area ALU subtract/compare unit behind a valid/ready handshake on both input and output.

---
 rtl/sub32_pkg.sv | 13 +
 rtl/sub_chunk.sv | 12 +
 rtl/sub32_serial.sv | 115 +++++++++++
 3 files changed

// File: rtl/sub32_pkg.sv
// sub32_pkg: FSM states, default sizing and saturation constants shared by sub32_serial.
package sub32_pkg;
  localparam int SUB_WIDTH = 32;
  localparam int SUB_CHUNK = 8;
  localparam int N_CHUNKS = SUB_WIDTH / SUB_CHUNK;
  localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [SUB_WIDTH-1:0] SAT_MAX = {1'b0, {(SUB_WIDTH-1){1'b1}}};
  localparam logic [SUB_WIDTH-1:0] SAT_MIN = {1'b1, {(SUB_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sub_chunk.sv
// sub_chunk: combinational W-bit subtract with borrow in/out.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);
  assign {bo, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
endmodule

// File: rtl/sub32_serial.sv
// sub32_serial: multi-cycle a - b - b_in, CHUNK bits per clock, valid/ready on both sides.
// Define SUB_SAT_EN to saturate diff on signed overflow.
module sub32_serial
  import sub32_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int CHUNK = SUB_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = idx_bits(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
`ifdef SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
`endif
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic borrow_q, borrow_d, b_out_q, b_out_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] ca, cb, cd;
  logic cbo;
  // one chunk slice is time-multiplexed across all N cycles by idx
  assign ca = a_q[idx_q*CHUNK +: CHUNK];
  assign cb = b_q[idx_q*CHUNK +: CHUNK];
  sub_chunk #(.W(CHUNK)) u_chunk (
    .a (ca),
    .b (cb),
    .bi(borrow_q),
    .d (cd),
    .bo(cbo)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    b_out_d  = b_out_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d      = a;
        b_d      = b;
        borrow_d = b_in;
        idx_d    = '0;
        diff_d   = '0;
        state_d  = RUN;
      end
      RUN: begin
        diff_d[idx_q*CHUNK +: CHUNK] = cd;
        borrow_d = cbo;
        idx_d    = idx_q + IW'(1);
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          b_out_d = cbo;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cd[CHUNK-1] != a_q[WIDTH-1]);
`ifdef SUB_SAT_EN
          if (ovf_d) diff_d = a_q[WIDTH-1] ? SAT_LO : SAT_HI;
`endif
          zero_d  = (diff_d == '0);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      b_out_q  <= b_out_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
endmodule
